uart_tx_buffered: RTL

Parametrised UART transmitter with an integrated write FIFO. It serialises DATA_WIDTH-bit words onto `tx` with configurable bit order, parity and stop-bit count. The host writes words into the FIFO; the transmitter drains it back-to-back with no idle gap. It sits between the register/bus side and the pad, and supersedes the single-word transmitter.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_tx_buffered.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, parity modes, baud divisor.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; full is a flop updated with the count.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             push;
    logic             pop;

    // Push is gated by the registered full, so a write on a pop edge while full is dropped.
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// UART transmitter fed by a write FIFO; frames are sent back-to-back while words are queued.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  overflow,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);
    localparam int unsigned CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned BW  = $clog2(DATA_WIDTH + 1);

    uart_state_t           state;
    logic [CW-1:0]         baud_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic                  par_bit;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic                  bit_end;
    logic                  last_stop;
    logic                  pop;

    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_word(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    uart_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .din   (din),
        .full  (full),
        .rd_en (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty)
    );

    assign bit_end    = (baud_cnt == CW'(CPB - 1));
    assign last_stop  = (state == ST_STOP) && bit_end && (bit_cnt == BW'(STOP_BITS - 1));
    assign pop        = ~fifo_empty && ((state == ST_IDLE) || last_stop);
    assign shreg_next = shift_word(shreg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            overflow <= wr_en & full;
            if (state != ST_IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);

            case (state)
                ST_IDLE: ;
                ST_START: begin
                    if (bit_end) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                        tx      <= head_bit(shreg);
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != PAR_NONE) begin
                                state <= ST_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= ST_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            shreg   <= shreg_next;
                            tx      <= head_bit(shreg_next);
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state   <= ST_STOP;
                        bit_cnt <= '0;
                        tx      <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (last_stop) begin
                            tx_done <= 1'b1;
                            state   <= ST_IDLE;
                            busy    <= 1'b0;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A pop starts the next frame and overrides the return to idle above.
            if (pop) begin
                state    <= ST_START;
                shreg    <= fifo_dout;
                par_bit  <= (PARITY == PAR_ODD) ? ~(^fifo_dout) : (^fifo_dout);
                tx       <= 1'b0;
                busy     <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end
    end

endmodule
